// File: rtl/rounding_div_pipe_if.sv
// Handshake bundle for rounding_div_pipe: upstream sample channel, downstream result channel.
// master drives samples and out_ready; slave is the divider side.
interface rounding_div_pipe_if #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 8,
   parameter int MAX_SHIFT = 7
);
   localparam int SHIFT_W = ($clog2(MAX_SHIFT + 1) > 1) ? $clog2(MAX_SHIFT + 1) : 1;

   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic [SHIFT_W-1:0]   in_shift;
   logic [1:0]           in_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_sat;
   logic [15:0]          sat_count;

   modport master (
      output in_valid, in_data, in_shift, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_sat, sat_count
   );

   modport slave (
      input  in_valid, in_data, in_shift, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_sat, sat_count
   );
endinterface

// File: rtl/rounding_div_pipe.sv
// Divide by 2^k with truncate / half-up / half-even rounding and saturation; 2-stage pipe, 2-cycle latency.
// Stages advance only into an empty or draining slot, so out_ready low stalls both stages without loss.
module rounding_div_pipe #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 8,
   parameter int MAX_SHIFT = 7
) (
   input logic                clk,
   input logic                rst,
   rounding_div_pipe_if.slave bus
);
   localparam int SHIFT_W = ($clog2(MAX_SHIFT + 1) > 1) ? $clog2(MAX_SHIFT + 1) : 1;
   localparam logic [SHIFT_W-1:0] MAX_K = SHIFT_W'(MAX_SHIFT);

   // Stage 1 registers
   logic                 r_s1_vld;
   logic [IN_WIDTH-1:0]  r_s1_q;
   logic                 r_s1_half;
   logic                 r_s1_sticky;
   logic [1:0]           r_s1_mode;

   // Stage 2 registers
   logic                 r_s2_vld;
   logic [OUT_WIDTH-1:0] r_s2_dat;
   logic                 r_s2_sat;
   logic [15:0]          r_sat_cnt;

   logic [SHIFT_W-1:0]   w_k;
   logic [IN_WIDTH-1:0]  w_low_mask;
   logic [IN_WIDTH-1:0]  w_q;
   logic                 w_half;
   logic                 w_sticky;
   logic                 w_s2_load;
   logic                 w_s1_adv;
   logic                 w_s1_load;
   logic                 w_up;
   logic [IN_WIDTH:0]    w_qr;
   logic                 w_ovf;
   logic [OUT_WIDTH-1:0] w_res;

   // w_low_mask covers the k discarded bits; its top bit is the half bit, the rest feed sticky.
   always_comb begin
      w_k        = (bus.in_shift > MAX_K) ? MAX_K : bus.in_shift;
      w_low_mask = (IN_WIDTH'(1) << w_k) - IN_WIDTH'(1);
      w_q        = bus.in_data >> w_k;
      w_half     = |(bus.in_data & (w_low_mask ^ (w_low_mask >> 1)));
      w_sticky   = |(bus.in_data & (w_low_mask >> 1));
   end

   assign w_s2_load    = !r_s2_vld || bus.out_ready;
   assign w_s1_adv     = r_s1_vld && w_s2_load;
   assign w_s1_load    = !r_s1_vld || w_s1_adv;
   assign bus.in_ready = w_s1_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld    <= 1'b0;
         r_s1_q      <= '0;
         r_s1_half   <= 1'b0;
         r_s1_sticky <= 1'b0;
         r_s1_mode   <= 2'b00;
      end else if (w_s1_load) begin
         r_s1_vld <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_q      <= w_q;
            r_s1_half   <= w_half;
            r_s1_sticky <= w_sticky;
            r_s1_mode   <= bus.in_mode;
         end
      end
   end

   always_comb begin
      w_up = 1'b0;
      case (r_s1_mode)
         2'b00:   w_up = 1'b0;
         2'b10:   w_up = r_s1_half && (r_s1_sticky || r_s1_q[0]);
         default: w_up = r_s1_half;
      endcase
      w_qr  = {1'b0, r_s1_q} + {{IN_WIDTH{1'b0}}, w_up};
      w_ovf = |w_qr[IN_WIDTH:OUT_WIDTH];
      w_res = w_ovf ? {OUT_WIDTH{1'b1}} : w_qr[OUT_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_s2_dat <= '0;
         r_s2_sat <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_dat <= w_res;
            r_s2_sat <= w_ovf;
         end
      end
   end

   // Counts delivered saturations only, and parks at all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sat_cnt <= 16'h0000;
      end else if (r_s2_vld && bus.out_ready && r_s2_sat && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign bus.out_valid = r_s2_vld;
   assign bus.out_data  = r_s2_dat;
   assign bus.out_sat   = r_s2_sat;
   assign bus.sat_count = r_sat_cnt;
endmodule

// File: tb/tb_rounding_div_pipe.sv
// Directed bench for rounding_div_pipe: hand-computed quotients, backpressure, clamp and async reset.
module tb_rounding_div_pipe;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rounding_div_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(8), .MAX_SHIFT(7)) bus ();
   rounding_div_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(8), .MAX_SHIFT(5)) bus5 ();

   rounding_div_pipe #(.IN_WIDTH(16), .OUT_WIDTH(8), .MAX_SHIFT(7)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   rounding_div_pipe #(.IN_WIDTH(16), .OUT_WIDTH(8), .MAX_SHIFT(5)) u_dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5.slave)
   );

   typedef struct {
      logic [7:0] dat;
      logic       sat;
      int         acc;
      bit         chk_lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   n_seen   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every delivered result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("out_data", {24'd0, bus.out_data}, {24'd0, e.dat});
            check("out_sat", {31'd0, bus.out_sat}, {31'd0, e.sat});
            if (e.chk_lat) check("latency", cyc - e.acc, 32'd2);
            n_seen++;
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [15:0] d, input logic [2:0] k, input logic [1:0] m,
                       input logic [7:0] ed, input logic es, input bit lat);
      exp_t e;
      int   t;
      bus.in_data  = d;
      bus.in_shift = k;
      bus.in_mode  = m;
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         bus.in_valid = 1'b0;
      end else begin
         e.dat = ed; e.sat = es; e.acc = cyc; e.chk_lat = lat;
         exp_q.push_back(e);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e3;
      int   seen0;
      int   leak;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shift = '0; bus.in_mode = 2'b00; bus.out_ready = 1'b1;
      bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.in_shift = '0; bus5.in_mode = 2'b00; bus5.out_ready = 1'b1;

      rst = 1'b1;
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_sat", {31'd0, bus.out_sat}, 32'd0);
      check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
      check("rst_sat_count", {16'd0, bus.sat_count}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

      // Back-to-back half-up, latency checked
      send(16'd73, 3'd3, 2'b01, 8'd9, 1'b0, 1'b1);
      send(16'd79, 3'd3, 2'b01, 8'd10, 1'b0, 1'b1);
      drain();

      // Rounding modes at k=3
      send(16'd12, 3'd3, 2'b10, 8'd2, 1'b0, 1'b0);
      send(16'd20, 3'd3, 2'b10, 8'd2, 1'b0, 1'b0);
      send(16'd12, 3'd3, 2'b01, 8'd2, 1'b0, 1'b0);
      send(16'd20, 3'd3, 2'b01, 8'd3, 1'b0, 1'b0);
      send(16'd12, 3'd3, 2'b00, 8'd1, 1'b0, 1'b0);
      send(16'd20, 3'd3, 2'b00, 8'd2, 1'b0, 1'b0);
      send(16'd79, 3'd3, 2'b11, 8'd10, 1'b0, 1'b0);
      send(16'd13, 3'd3, 2'b10, 8'd2, 1'b0, 1'b0);
      send(16'd28, 3'd3, 2'b10, 8'd4, 1'b0, 1'b0);
      send(16'd9,  3'd1, 2'b10, 8'd4, 1'b0, 1'b0);
      send(16'd2044, 3'd3, 2'b00, 8'd255, 1'b0, 1'b0);
      drain();

      // Saturation and counter
      check("sat_count_0", {16'd0, bus.sat_count}, 32'd0);
      send(16'd2045, 3'd3, 2'b01, 8'hFF, 1'b1, 1'b0);
      drain();
      check("sat_count_1", {16'd0, bus.sat_count}, 32'd1);
      send(16'd300, 3'd0, 2'b01, 8'hFF, 1'b1, 1'b0);
      send(16'd200, 3'd0, 2'b01, 8'd200, 1'b0, 1'b0);
      drain();
      check("sat_count_2", {16'd0, bus.sat_count}, 32'd2);

      // Shift 15 on a 3-bit field lands on k=7: 0x1234/128 -> 0x24
      send(16'h1234, 3'(15), 2'b01, 8'h24, 1'b0, 1'b0);
      drain();

      // Shift 7 clamped to 5 on the narrower instance: 0x1234/32 = 145.6 -> 146
      bus5.in_data = 16'h1234; bus5.in_shift = 3'd7; bus5.in_mode = 2'b01; bus5.in_valid = 1'b1;
      @(posedge clk); #1;
      bus5.in_valid = 1'b0;
      @(posedge clk); #1;
      check("clamp_valid", {31'd0, bus5.out_valid}, 32'd1);
      check("clamp_data", {24'd0, bus5.out_data}, 32'd146);
      check("clamp_sat", {31'd0, bus5.out_sat}, 32'd0);
      check("clamp_sat_count", {16'd0, bus5.sat_count}, 32'd0);

      // Backpressure: two accepted, third stalls until out_ready rises
      seen0 = n_seen;
      bus.out_ready = 1'b0;
      send(16'd40, 3'd2, 2'b00, 8'd10, 1'b0, 1'b0);
      send(16'd45, 3'd2, 2'b01, 8'd11, 1'b0, 1'b0);
      bus.in_data = 16'd50; bus.in_shift = 3'd2; bus.in_mode = 2'b01; bus.in_valid = 1'b1;
      #1;
      check("in_ready_stall", {31'd0, bus.in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("in_ready_stall2", {31'd0, bus.in_ready}, 32'd0);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_data", {24'd0, bus.out_data}, 32'd10);
      e3.dat = 8'd13; e3.sat = 1'b0; e3.acc = cyc; e3.chk_lat = 1'b0;
      exp_q.push_back(e3);
      bus.out_ready = 1'b1;
      #1;
      check("in_ready_release", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      drain();
      check("bp_count", n_seen - seen0, 32'd3);

      // Async reset with both stages full
      bus.out_ready = 1'b0;
      send(16'd100, 3'd0, 2'b00, 8'd100, 1'b0, 1'b0);
      send(16'd101, 3'd0, 2'b00, 8'd101, 1'b0, 1'b0);
      check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      check("pre_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("async_rst_sat_count", {16'd0, bus.sat_count}, 32'd0);
      check("async_rst_data", {24'd0, bus.out_data}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      leak = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.out_valid) leak++;
      end
      check("post_rst_leak", leak, 32'd0);
      @(posedge clk); #1;
      send(16'd79, 3'd3, 2'b01, 8'd10, 1'b0, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
